// File: rtl/snake_step_ctrl_if.sv
// Move-offer channel between the snake step controller and the playfield writer.
// The controller drives the offered head cell and direction; the writer answers with step_ready.
interface snake_step_ctrl_if;
    logic       step_valid;
    logic       step_ready;
    logic [7:0] head_x;
    logic [7:0] head_y;
    logic [1:0] dir;

    modport master (
        output step_valid,
        output head_x,
        output head_y,
        output dir,
        input  step_ready
    );

    modport slave (
        input  step_valid,
        input  head_x,
        input  head_y,
        input  dir,
        output step_ready
    );
endinterface

// File: rtl/snake_step_ctrl.sv
// Snake head sequencer: divides clk into game steps, arbitrates latched direction buttons,
// computes the next head cell, detects wall collisions and offers each move over valid/ready.
module snake_step_ctrl #(
    parameter int X_MAX    = 20,
    parameter int Y_MAX    = 30,
    parameter int TICK_DIV = 16,
    parameter int START_X  = 10,
    parameter int START_Y  = 15
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               left,
    input  logic               right,
    input  logic               up,
    input  logic               down,
    input  logic               start,
    snake_step_ctrl_if.master  step,
    output logic               running,
    output logic               game_over
);
    localparam int CW = $clog2(TICK_DIV);
    localparam logic signed [8:0] XLIM = 9'(X_MAX);
    localparam logic signed [8:0] YLIM = 9'(Y_MAX);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_STEP, S_DEAD} state_t;

    state_t          r_state, w_next;
    logic [CW-1:0]   r_cnt;
    logic [7:0]      r_x, r_y, r_nx, r_ny;
    logic [1:0]      r_dir, r_ndir;
    logic [3:0]      r_pend;

    logic [3:0]        w_btn, w_cand;
    logic [1:0]        w_dir;
    logic              w_found, w_tick, w_hit;
    logic signed [8:0] w_sx, w_sy;

    // Bit index of each button equals its direction code.
    assign w_btn  = {down, up, right, left};
    assign w_cand = r_pend | w_btn;
    assign w_tick = (r_state == S_RUN) && (r_cnt == CW'(TICK_DIV - 1));

    // Highest-priority pending direction that does not reverse the current heading.
    always_comb begin
        w_dir   = r_dir;
        w_found = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (!w_found && w_cand[i] && (2'(i) != (r_dir ^ 2'b01))) begin
                w_dir   = 2'(i);
                w_found = 1'b1;
            end
        end
    end

    always_comb begin
        w_sx = signed'({1'b0, r_x});
        w_sy = signed'({1'b0, r_y});
        case (w_dir)
            2'd0:    w_sx = w_sx - 9'sd1;
            2'd1:    w_sx = w_sx + 9'sd1;
            2'd2:    w_sy = w_sy - 9'sd1;
            default: w_sy = w_sy + 9'sd1;
        endcase
        w_hit = (w_sx < 9'sd0) || (w_sx >= XLIM) || (w_sy < 9'sd0) || (w_sy >= YLIM);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (start)           w_next = S_RUN;
            S_RUN:  if (w_tick)          w_next = w_hit ? S_DEAD : S_STEP;
            S_STEP: if (step.step_ready) w_next = S_RUN;
            S_DEAD: if (start)           w_next = S_RUN;
            default:                     w_next = S_IDLE;
        endcase
    end

    always_comb begin
        step.step_valid = (r_state == S_STEP);
        step.head_x     = step.step_valid ? r_nx   : r_x;
        step.head_y     = step.step_valid ? r_ny   : r_y;
        step.dir        = step.step_valid ? r_ndir : r_dir;
        running         = (r_state == S_RUN) || (r_state == S_STEP);
        game_over       = (r_state == S_DEAD);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cnt  <= '0;
            r_x    <= 8'(START_X);
            r_y    <= 8'(START_Y);
            r_dir  <= '0;
            r_nx   <= 8'(START_X);
            r_ny   <= 8'(START_Y);
            r_ndir <= '0;
            r_pend <= '0;
        end else begin
            case (r_state)
                S_IDLE: r_cnt <= '0;
                S_RUN: begin
                    r_pend <= r_pend | w_btn;
                    if (w_tick) begin
                        r_cnt <= '0;
                        if (!w_hit) begin
                            r_nx   <= w_sx[7:0];
                            r_ny   <= w_sy[7:0];
                            r_ndir <= w_dir;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_STEP: begin
                    // Presses in the accept cycle survive the clear.
                    if (step.step_ready) begin
                        r_x    <= r_nx;
                        r_y    <= r_ny;
                        r_dir  <= r_ndir;
                        r_pend <= w_btn;
                    end else begin
                        r_pend <= r_pend | w_btn;
                    end
                end
                S_DEAD: begin
                    if (start) begin
                        r_x    <= 8'(START_X);
                        r_y    <= 8'(START_Y);
                        r_dir  <= '0;
                        r_pend <= '0;
                        r_cnt  <= '0;
                    end
                end
                default: r_cnt <= '0;
            endcase
        end
    end
endmodule

// File: tb/tb_snake_step_ctrl.sv
// Randomized bench for snake_step_ctrl: a game-level reference model predicts every move offer
// into a scoreboard queue; a monitor pops and compares offers and checks visible status each cycle.
module tb_snake_step_ctrl;
    localparam int XM = 8;
    localparam int YM = 6;
    localparam int TD = 5;
    localparam int SX = 4;
    localparam int SY = 3;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic left = 1'b0, right = 1'b0, up = 1'b0, down = 1'b0, start = 1'b0;
    logic running, game_over;

    snake_step_ctrl_if bus ();

    snake_step_ctrl #(
        .X_MAX   (XM),
        .Y_MAX   (YM),
        .TICK_DIV(TD),
        .START_X (SX),
        .START_Y (SY)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .left     (left),
        .right    (right),
        .up       (up),
        .down     (down),
        .start    (start),
        .step     (bus.master),
        .running  (running),
        .game_over(game_over)
    );

    always #5 clk = ~clk;

    int tests  = 0;
    int failed = 0;
    int cyc    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s @cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    typedef struct {
        int x;
        int y;
        int d;
        int cyc;
    } offer_t;
    offer_t sb[$];

    typedef enum {M_IDLE, M_MOVE, M_OFFER, M_DEAD} mmode_t;
    mmode_t mode = M_IDLE;

    // Direction codes 0=left 1=right 2=up 3=down.
    int DX[4]  = '{-1, 1, 0, 0};
    int DY[4]  = '{0, 0, -1, 1};
    int OPP[4] = '{1, 0, 3, 2};

    int hx = SX, hy = SY, hd = 0;
    int ox = SX, oy = SY, od = 0;
    int waitc = 0;
    bit press[4];
    bit btn[4];
    int nd, nx, ny;
    bit found;

    always @(posedge clk) begin
        cyc++;
        btn = '{left, right, up, down};
        if (!reset_n) begin
            mode = M_IDLE;
            hx = SX; hy = SY; hd = 0;
            waitc = 0;
            for (int k = 0; k < 4; k++) press[k] = 1'b0;
        end else begin
            case (mode)
                M_IDLE: if (start) begin mode = M_MOVE; waitc = 0; end
                M_MOVE: begin
                    for (int k = 0; k < 4; k++) press[k] = press[k] | btn[k];
                    if (waitc == TD - 1) begin
                        waitc = 0;
                        nd = hd;
                        found = 1'b0;
                        for (int k = 0; k < 4; k++)
                            if (!found && press[k] && k != OPP[hd]) begin nd = k; found = 1'b1; end
                        nx = hx + DX[nd];
                        ny = hy + DY[nd];
                        if (nx < 0 || nx >= XM || ny < 0 || ny >= YM) begin
                            mode = M_DEAD;
                        end else begin
                            ox = nx; oy = ny; od = nd;
                            mode = M_OFFER;
                            sb.push_back('{ox, oy, od, cyc});
                        end
                    end else begin
                        waitc++;
                    end
                end
                M_OFFER: begin
                    if (bus.step_ready) begin
                        hx = ox; hy = oy; hd = od;
                        for (int k = 0; k < 4; k++) press[k] = btn[k];
                        mode = M_MOVE;
                    end else begin
                        for (int k = 0; k < 4; k++) press[k] = press[k] | btn[k];
                    end
                end
                M_DEAD: begin
                    if (start) begin
                        hx = SX; hy = SY; hd = 0;
                        waitc = 0;
                        for (int k = 0; k < 4; k++) press[k] = 1'b0;
                        mode = M_MOVE;
                    end
                end
                default: mode = M_IDLE;
            endcase
        end
    end

    // Monitor: sampled mid-cycle, inputs change just after the rising edge.
    logic pv = 1'b0, pr = 1'b0;
    offer_t got;
    always @(negedge clk) begin
        check("step_valid", 32'(bus.step_valid), 32'(mode == M_OFFER));
        check("running",    32'(running),        32'(mode == M_MOVE || mode == M_OFFER));
        check("game_over",  32'(game_over),      32'(mode == M_DEAD));
        check("head_x", 32'(bus.head_x), 32'((mode == M_OFFER) ? ox : hx));
        check("head_y", 32'(bus.head_y), 32'((mode == M_OFFER) ? oy : hy));
        check("dir",    32'(bus.dir),    32'((mode == M_OFFER) ? od : hd));
        if (bus.step_valid === 1'b1 && (!pv || pr)) begin
            if (sb.size() == 0) begin
                check("offer_unexpected", 32'(1), 32'(0));
            end else begin
                got = sb.pop_front();
                check("offer_x",     32'(bus.head_x), 32'(got.x));
                check("offer_y",     32'(bus.head_y), 32'(got.y));
                check("offer_dir",   32'(bus.dir),    32'(got.d));
                check("offer_cycle", 32'(cyc),        32'(got.cyc));
            end
        end
        pv = bus.step_valid;
        pr = bus.step_ready;
    end

    initial begin
        int phase;
        bus.step_ready = 1'b0;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0; bus.step_ready = 1'b1;
        repeat (40) @(posedge clk);
        for (int i = 0; i < 6000; i++) begin
            @(posedge clk); #1;
            phase = (i / 500) % 3;
            case (phase)
                0:       bus.step_ready = 1'b1;
                1:       bus.step_ready = 1'($urandom_range(0, 1));
                default: bus.step_ready = ($urandom_range(0, 59) == 0);
            endcase
            left    = ($urandom_range(0, 7) == 0);
            right   = ($urandom_range(0, 7) == 0);
            up      = ($urandom_range(0, 7) == 0);
            down    = ($urandom_range(0, 7) == 0);
            start   = ($urandom_range(0, 24) == 0);
            reset_n = ($urandom_range(0, 399) != 0);
        end
        @(posedge clk); #1;
        reset_n = 1'b1; start = 1'b0;
        left = 1'b0; right = 1'b0; up = 1'b0; down = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check("scoreboard_drained", 32'(sb.size()), 32'(0));
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
